// File: rtl/lb_regbank_arbiter.sv
// Round-robin arbiter that shares one register bank among NUM_REQ requesters.
// Every access takes a fixed IDLE -> GRANT -> RESP slot of three cycles.
module lb_regbank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      bank_cs,
  output logic                      bank_we,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [DATA_W-1:0]         bank_wdata,
  input  logic [DATA_W-1:0]         bank_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]         state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] ack_reg;
  logic               cs_reg;
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   win_reg;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
  int                 cand;
  logic [PTR_W-1:0]   cand_idx;
  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;

  always_comb begin
    cand      = 0;
    cand_idx  = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   rr_ptr_next;

  assign win_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign rr_ptr_next = (win_reg == PTR_W'(NUM_REQ - 1)) ? '0 : win_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      gnt_reg    <= '0;
      ack_reg    <= '0;
      cs_reg     <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      rr_ptr_reg <= '0;
      win_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (win_valid) begin
            win_reg   <= win_idx;
            gnt_reg   <= win_onehot;
            cs_reg    <= 1'b1;
            we_reg    <= req_we[win_idx];
            addr_reg  <= addr_arr[win_idx];
            wdata_reg <= wdata_arr[win_idx];
            state_reg <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // bank_rdata is combinational from bank_addr, so it is valid now.
          if (!we_reg) rdata_reg <= bank_rdata;
          cs_reg    <= 1'b0;
          we_reg    <= 1'b0;
          ack_reg   <= gnt_reg;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          ack_reg    <= '0;
          gnt_reg    <= '0;
          rr_ptr_reg <= rr_ptr_next;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_reg;
  assign ack        = ack_reg;
  assign rsp_rdata  = rdata_reg;
  assign bank_cs    = cs_reg;
  assign bank_we    = we_reg;
  assign bank_addr  = addr_reg;
  assign bank_wdata = wdata_reg;

endmodule

// File: tb/tb_lb_regbank_arbiter.sv
// Bench for lb_regbank_arbiter: directed scenarios plus random traffic, checked
// every cycle against a slot-level reference model of the arbiter and its bank.
module tb_lb_regbank_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic [DW-1:0] rsp_rdata;
  logic          bank_cs;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] bank_rdata;

  logic [AW-1:0] r_addr  [N];
  logic [DW-1:0] r_wdata [N];
  logic          mem_clr;
  logic [DW-1:0] mem [2**AW];

  lb_regbank_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rsp_rdata(rsp_rdata), .bank_cs(bank_cs), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
  end

  // The register bank itself: combinational read, write on cs&we.
  assign bank_rdata = mem[bank_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (bank_cs && bank_we) begin
      mem[bank_addr] <= bank_wdata;
    end
  end

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int ack_q[$];
  int ack_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one access occupies a 3-cycle slot (phase 0 free, 1 bank, 2 ack).
  int            m_phase = 0;
  int            m_ptr = 0;
  int            m_cur = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] exp_mem [2**AW];
  logic [N-1:0]  e_gnt = '0;
  logic [N-1:0]  e_ack = '0;
  logic          e_cs = 1'b0;
  logic          e_bwe = 1'b0;
  logic [AW-1:0] e_baddr = '0;
  logic [DW-1:0] e_bwdata = '0;
  logic [DW-1:0] e_rdata = '0;

  task automatic model_step();
    // The bank sees cs during the bank phase even if reset lands on that edge.
    if (mem_clr) begin
      for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
    end else if (m_phase == 1 && m_we) begin
      exp_mem[m_addr] = m_wdata;
    end
    if (reset) begin
      m_phase = 0; m_ptr = 0;
      e_gnt = '0; e_ack = '0; e_cs = 1'b0; e_bwe = 1'b0;
      e_baddr = '0; e_bwdata = '0; e_rdata = '0;
    end else begin
      case (m_phase)
        0: begin
          e_cs = 1'b0; e_bwe = 1'b0; e_gnt = '0; e_ack = '0;
          if (req != '0) begin
            for (int k = 0; k < N; k++) begin
              int idx;
              idx = (m_ptr + k) % N;
              if (req[idx]) begin
                m_cur = idx;
                break;
              end
            end
            m_we = req_we[m_cur]; m_addr = r_addr[m_cur]; m_wdata = r_wdata[m_cur];
            e_cs = 1'b1; e_bwe = m_we; e_baddr = m_addr; e_bwdata = m_wdata;
            e_gnt = N'(1) << m_cur;
            m_phase = 1;
          end
        end
        1: begin
          if (!m_we) e_rdata = exp_mem[m_addr];
          e_cs = 1'b0; e_bwe = 1'b0;
          e_ack = N'(1) << m_cur;
          m_phase = 2;
        end
        default: begin
          e_ack = '0; e_gnt = '0;
          m_ptr = (m_cur + 1) % N;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("ack", 32'(ack), 32'(e_ack));
    check("bank_cs", 32'(bank_cs), 32'(e_cs));
    check("bank_we", 32'(bank_we), 32'(e_bwe));
    check("bank_addr", 32'(bank_addr), 32'(e_baddr));
    check("bank_wdata", 32'(bank_wdata), 32'(e_bwdata));
    check("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_q.push_back(i);
        ack_cyc.push_back(cyc);
        $display("[TB] cyc=%0d ack req%0d we=%0b addr=%0d wdata=%h rdata=%h",
                 cyc, i, req_we[i], r_addr[i], r_wdata[i], rsp_rdata);
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic run_acks(input int n, input int budget);
    int start;
    int spent;
    start = ack_q.size();
    spent = 0;
    while (ack_q.size() - start < n && spent < budget) begin
      cycle();
      spent++;
    end
    if (ack_q.size() - start < n) check("ack_timeout", 32'(ack_q.size() - start), 32'(n));
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]  = we;
    r_addr[i]  = a;
    r_wdata[i] = d;
    req[i]     = 1'b1;
  endtask

  initial begin
    int base;
    int spent;
    reset = 1'b1; mem_clr = 1'b1; req = '0; req_we = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_wdata[i] = '0; end
    repeat (2) cycle();
    reset = 1'b0; mem_clr = 1'b0;

    // Idle after reset: everything stays low.
    repeat (10) cycle();

    // Single write from requester 2.
    set_req(2, 1'b1, 4'd5, 8'hA5);
    run_acks(1, 10);
    check("t2_winner", 32'(ack_q[$]), 32'd2);

    // Read back through requester 1.
    set_req(1, 1'b0, 4'd5, 8'h00);
    run_acks(1, 10);
    check("t3_winner", 32'(ack_q[$]), 32'd1);
    check("t3_rdata", 32'(rsp_rdata), 32'hA5);

    // Fresh pointer, all four requesting: strict order 0..3 every 3 cycles.
    reset = 1'b1; cycle(); reset = 1'b0;
    base = ack_q.size();
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    run_acks(4, 30);
    for (int i = 0; i < N; i++) check("t4_order", 32'(ack_q[base+i]), 32'(i));
    for (int i = 1; i < N; i++) check("t4_spacing", 32'(ack_cyc[base+i] - ack_cyc[base+i-1]), 32'd3);

    // Pointer wrapped to 0: requests 0 and 3 are served 0 first, then 3.
    base = ack_q.size();
    set_req(0, 1'b0, 4'd5, 8'h00);
    set_req(3, 1'b0, 4'd2, 8'h00);
    run_acks(2, 20);
    check("t5_first", 32'(ack_q[base]), 32'd0);
    check("t5_second", 32'(ack_q[base+1]), 32'd3);
    base = ack_q.size();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    run_acks(4, 30);
    check("t5_ptr_wrap", 32'(ack_q[base]), 32'd0);

    // Reset while a write is in its bank cycle: no ack, requester retries.
    set_req(2, 1'b1, 4'd3, 8'h5A);
    spent = 0;
    while (!bank_cs && spent < 5) begin cycle(); spent++; end
    check("t6_reached_grant", 32'(bank_cs), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_no_ack", 32'(ack), 32'd0);
    check("t6_no_gnt", 32'(gnt), 32'd0);
    base = ack_q.size();
    set_req(0, 1'b0, 4'd3, 8'h00);
    run_acks(2, 20);
    check("t6_ptr_reset", 32'(ack_q[base]), 32'd0);
    check("t6_retry", 32'(ack_q[base+1]), 32'd2);

    // Random traffic with occasional early req drop and stray resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        else if (req[i] && gnt[i] && $urandom_range(0, 19) == 0)
          req[i] = 1'b0;
      end
      reset = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;
    repeat (20) cycle();
    req = '0;
    repeat (6) cycle();
    check("drain_idle_cs", 32'(bank_cs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
